// File: rtl/board_led_scanner_if.sv
// board_led_scanner_if: board state (pos1..pos9, win) toward the scanner and LED drive (row_n, red, green, frame_start) back; master = board side, slave = scanner
interface board_led_scanner_if;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, win;
  logic [2:0] row_n, red, green;
  logic frame_start;
  modport master(
    output pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, win,
    input row_n, red, green, frame_start
  );
  modport slave(
    input pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, win,
    output row_n, red, green, frame_start
  );
endinterface

// File: rtl/board_led_scanner.sv
// board_led_scanner: 3x3 red/green row scan of a per-frame board snapshot with row blanking and winner blink; clk, reset (async active-low), bus (slave: pos1..pos9/win in, row_n/red/green/frame_start out)
module board_led_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYC = 1000,
  parameter int BLINK_DIV = 64
) (
  input logic clk,
  input logic reset,
  board_led_scanner_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] row, row_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic blink_on, blink_nxt;
  logic [8:0][1:0] pos_in, sp;
  logic [2:0][1:0] cells;
  logic [1:0] sw;
  logic snap, slot_end, frame_end, blink_wrap;
  logic [2:0] red_nxt, green_nxt;
  function automatic logic [1:0] lit(input logic [1:0] code, input logic [1:0] w, input logic on);
    logic hide;
    hide = !on && (w == 2'b11 ? code != 2'b00 : code == w && w != 2'b00);
    return hide ? 2'b00 : {code == 2'b10, code == 2'b01};
  endfunction
  assign pos_in = {bus.pos9, bus.pos8, bus.pos7, bus.pos6, bus.pos5, bus.pos4, bus.pos3, bus.pos2, bus.pos1};
  always_comb begin
    snap = cnt == '0 && row == 2'd0;
    slot_end = cnt == CW'(SCAN_DIV - 1);
    frame_end = state != IDLE && slot_end && row == 2'd2;
    blink_wrap = frame_end && fcnt == FW'(BLINK_DIV - 1);
    cnt_nxt = state == IDLE || slot_end ? '0 : cnt + 1'b1;
    row_nxt = state == IDLE || !slot_end ? row : row == 2'd2 ? 2'd0 : row + 2'd1;
    state_nxt = state == IDLE || cnt_nxt < CW'(BLANK_CYC) ? BLANK : DRIVE;
    fcnt_nxt = sw == 2'b00 || blink_wrap ? '0 : frame_end ? fcnt + 1'b1 : fcnt;
    blink_nxt = sw == 2'b00 ? 1'b1 : blink_wrap ? !blink_on : blink_on;
    cells = row == 2'd0 ? sp[2:0] : row == 2'd1 ? sp[5:3] : sp[8:6];
    {green_nxt[0], red_nxt[0]} = lit(cells[0], sw, blink_on);
    {green_nxt[1], red_nxt[1]} = lit(cells[1], sw, blink_on);
    {green_nxt[2], red_nxt[2]} = lit(cells[2], sw, blink_on);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      row <= 2'd0;
      fcnt <= '0;
      blink_on <= 1'b1;
      sp <= '0;
      sw <= 2'b00;
      bus.row_n <= 3'b111;
      bus.red <= 3'b000;
      bus.green <= 3'b000;
      bus.frame_start <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      row <= row_nxt;
      fcnt <= fcnt_nxt;
      blink_on <= blink_nxt;
      if (snap) begin
        sp <= pos_in;
        sw <= bus.win;
      end
      bus.frame_start <= state != IDLE && snap;
      bus.row_n <= state == DRIVE ? ~(3'b001 << row) : 3'b111;
      bus.red <= state == DRIVE ? red_nxt : 3'b000;
      bus.green <= state == DRIVE ? green_nxt : 3'b000;
    end
  end
endmodule

// File: tb/tb_board_led_scanner.sv
// tb_board_led_scanner: scoreboard bench for board_led_scanner with a position-based display model
module tb_board_led_scanner;
  localparam int SD = 8, BC = 2, BD = 2, FP = 3 * SD;
  localparam logic [17:0] B2 = 18'h10201, B3 = 18'h10209, B5 = 18'h00870;
  typedef struct packed {logic [2:0] row_n, red, green; logic fs;} out_t;
  logic clk = 1'b0, reset = 1'b0;
  int n_cmp = 0, n_bad = 0;
  out_t q[$];
  out_t x, y;
  int e, d, p, c, r;
  logic [17:0] snap_b;
  logic [1:0] snap_w, code;
  logic hide;
  board_led_scanner_if bus();
  board_led_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_board(input logic [17:0] b, input logic [1:0] w);
    bus.pos1 = b[1:0];
    bus.pos2 = b[3:2];
    bus.pos3 = b[5:4];
    bus.pos4 = b[7:6];
    bus.pos5 = b[9:8];
    bus.pos6 = b[11:10];
    bus.pos7 = b[13:12];
    bus.pos8 = b[15:14];
    bus.pos9 = b[17:16];
    bus.win = w;
  endtask
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 4 * FP);
    if (!bus.frame_start) chk("fs_timeout", 32'(bus.frame_start), 32'd1);
  endtask
  task automatic chk_off(input string tag);
    chk({tag, "_row_n"}, 32'(bus.row_n), 32'h7);
    chk({tag, "_red"}, 32'(bus.red), 32'h0);
    chk({tag, "_green"}, 32'(bus.green), 32'h0);
    chk({tag, "_fs"}, 32'(bus.frame_start), 32'h0);
  endtask
  // p is the counter position the DUT output after this edge reflects; snapshot and blink age update at frame starts
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e = 0;
      d = 0;
      snap_b = '0;
      snap_w = '0;
      q.delete();
    end else begin
      e++;
      x = {3'b111, 7'b0};
      if (e >= 2) begin
        p = e - 2;
        c = p % SD;
        r = (p / SD) % 3;
        if (p % FP == 0) begin
          if (p > 0) d = snap_w == 2'b00 ? 0 : d + 1;
          snap_b = {bus.pos9, bus.pos8, bus.pos7, bus.pos6, bus.pos5, bus.pos4, bus.pos3, bus.pos2, bus.pos1};
          snap_w = bus.win;
        end
        x.fs = p % FP == 0;
        if (c >= BC) begin
          x.row_n = ~(3'b001 << r);
          for (int k = 0; k < 3; k++) begin
            code = snap_b[2 * (3 * r + k) +: 2];
            hide = snap_w != 2'b00 && (d / BD) % 2 == 1 && (snap_w == 2'b11 ? code != 2'b00 : code == snap_w);
            x.red[k] = code == 2'b01 && !hide;
            x.green[k] = code == 2'b10 && !hide;
          end
        end
      end
      q.push_back(x);
    end
  end
  always @(negedge clk) begin
    if (reset && q.size() > 0) begin
      y = q.pop_front();
      chk("row_n", 32'(bus.row_n), 32'(y.row_n));
      chk("red", 32'(bus.red), 32'(y.red));
      chk("green", 32'(bus.green), 32'(y.green));
      chk("frame_start", 32'(bus.frame_start), 32'(y.fs));
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    set_board(18'h0, 2'b00);
    repeat (5) begin
      @(negedge clk);
      #1 chk_off("in_reset");
    end
    #1 reset = 1'b1;
    wait_fs();
    set_board(B2, 2'b00);
    repeat (2) wait_fs();
    repeat (10) @(negedge clk);
    set_board(B3, 2'b00);
    repeat (2) wait_fs();
    set_board(B2, 2'b01);
    repeat (6) wait_fs();
    set_board(B2, 2'b00);
    repeat (2) wait_fs();
    set_board(B5, 2'b11);
    repeat (7) wait_fs();
    repeat (12) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_off("mid_row_reset");
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) wait_fs();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
